// File: rtl/clint_timer_pkg.sv
// Shared CLINT definitions: register offsets, bus FSM states and the byte-merge helper.
package clint_timer_pkg;

  localparam logic [63:0] CLINT_MSIP_OFF     = 64'h0000_0000_0000_0000;
  localparam logic [63:0] CLINT_MTIMECMP_OFF = 64'h0000_0000_0000_4000;
  localparam logic [63:0] CLINT_MTIME_OFF    = 64'h0000_0000_0000_BFF8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } clint_state_e;

  // Replace only the bytes whose strobe is set.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  wstrb);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (wstrb[i]) res[8*i +: 8] = wdata[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_tick_gen.sv
// Prescaler for mtime: emits a one-cycle tick every TICK_DIV core clocks.
module clint_tick_gen #(
  parameter int unsigned TICK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam logic [15:0] LAST_CNT = 16'(TICK_DIV - 1);

  logic [15:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == LAST_CNT);

  always_comb begin
    cnt_d = tick_o ? 16'd0 : cnt_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= 16'd0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/clint_timer.sv
// Core-local interruptor: mtime/mtimecmp/msip behind a valid/ready request and response channel.
module clint_timer
  import clint_timer_pkg::*;
#(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 2
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        time_irq,
  output logic        soft_irq,
  output logic [63:0] mtime_o
);

  clint_state_e state_q, state_d;
  logic [63:0]  mtime_q, mtime_d;
  logic [63:0]  mtimecmp_q, mtimecmp_d;
  logic         msip_q, msip_d;
  logic [63:0]  rdata_q, rdata_d;
  logic         err_q, err_d;
  logic         time_irq_q, soft_irq_q;
  logic         tick;
  logic [63:0]  offset;
  logic         aligned, hit_msip, hit_mtimecmp, hit_mtime, hit_any;

  clint_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (cpu_clk_50M),
    .rst_ni (cpu_rst_n),
    .tick_o (tick)
  );

  assign offset       = req_addr - BASE_ADDR;
  assign aligned      = (req_addr[2:0] == 3'b000);
  assign hit_msip     = aligned && (offset == CLINT_MSIP_OFF);
  assign hit_mtimecmp = aligned && (offset == CLINT_MTIMECMP_OFF);
  assign hit_mtime    = aligned && (offset == CLINT_MTIME_OFF);
  assign hit_any      = hit_msip || hit_mtimecmp || hit_mtime;

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign time_irq   = time_irq_q;
  assign soft_irq   = soft_irq_q;
  assign mtime_o    = mtime_q;

  always_comb begin
    state_d    = state_q;
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    if (state_q == ST_IDLE) begin
      if (req_valid) begin
        state_d = ST_RESP;
        rdata_d = 64'd0;
        err_d   = !hit_any;
        if (req_we) begin
          // A software write to mtime wins over a coincident tick.
          if (hit_mtime)    mtime_d    = merge_bytes(mtime_q, req_wdata, req_wstrb);
          if (hit_mtimecmp) mtimecmp_d = merge_bytes(mtimecmp_q, req_wdata, req_wstrb);
          if (hit_msip && req_wstrb[0]) msip_d = req_wdata[0];
        end else begin
          if (hit_mtime)    rdata_d = mtime_q;
          if (hit_mtimecmp) rdata_d = mtimecmp_q;
          if (hit_msip)     rdata_d = {63'd0, msip_q};
        end
      end
    end else begin
      if (resp_ready) state_d = ST_IDLE;
    end
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q    <= ST_IDLE;
      mtime_q    <= 64'd0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_q     <= 1'b0;
      rdata_q    <= 64'd0;
      err_q      <= 1'b0;
      time_irq_q <= 1'b0;
      soft_irq_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      // Interrupt lines follow the pre-edge register values, one edge behind.
      time_irq_q <= (mtime_q >= mtimecmp_q);
      soft_irq_q <= msip_q;
    end
  end

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench: instance a uses TICK_DIV=2, instance b TICK_DIV=1; both see the same bus traffic.
module tb_clint_timer;

  localparam logic [63:0] A_MSIP  = 64'h0000_0000_0200_0000;
  localparam logic [63:0] A_MCMP  = 64'h0000_0000_0200_4000;
  localparam logic [63:0] A_MTIME = 64'h0000_0000_0200_BFF8;
  localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk, rst_n;
  logic        req_valid, req_we, resp_ready;
  logic [63:0] req_addr, req_wdata;
  logic [7:0]  req_wstrb;

  logic        a_req_ready, a_resp_valid, a_resp_err, a_time_irq, a_soft_irq;
  logic [63:0] a_resp_rdata, a_mtime_o;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_time_irq, b_soft_irq;
  logic [63:0] b_resp_rdata, b_mtime_o;

  int pass_cnt  = 0;
  int total_cnt = 0;

  clint_timer #(.TICK_DIV(2)) dut_a (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n),
    .req_valid(req_valid), .req_ready(a_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(a_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(a_resp_rdata), .resp_err(a_resp_err),
    .time_irq(a_time_irq), .soft_irq(a_soft_irq), .mtime_o(a_mtime_o)
  );

  clint_timer #(.TICK_DIV(1)) dut_b (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n),
    .req_valid(req_valid), .req_ready(b_req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(b_resp_valid), .resp_ready(resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err),
    .time_irq(b_time_irq), .soft_irq(b_soft_irq), .mtime_o(b_mtime_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // One transaction on instance a; called right after a sample point (posedge + 1).
  task automatic bus(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [7:0] wstrb, output logic [63:0] rdata, output logic err,
                     output logic rv_first, output logic rv_after);
    int guard;
    guard = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = wstrb;
    while (!a_req_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rv_first = a_resp_valid; rdata = a_resp_rdata; err = a_resp_err;
    @(posedge clk); #1;
    rv_after = a_resp_valid;
    $display("bus we=%0d addr=%h wdata=%h wstrb=%h -> rdata=%h err=%0d", we, addr, wdata, wstrb, rdata, err);
  endtask

  task automatic test_reset();
    logic irq_seen;
    irq_seen = 1'b0;
    #12;
    total_cnt++; if (a_req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b expected 1", a_req_ready); else pass_cnt++;
    total_cnt++; if (a_resp_valid !== 1'b0) $display("FAIL rst_resp_valid: got %b expected 0", a_resp_valid); else pass_cnt++;
    total_cnt++; if ({a_resp_err, a_resp_rdata} !== 65'd0) $display("FAIL rst_resp: got %h expected 0", {a_resp_err, a_resp_rdata}); else pass_cnt++;
    total_cnt++; if ({a_time_irq, a_soft_irq, a_mtime_o} !== 66'd0) $display("FAIL rst_irq_mtime: got %h expected 0", {a_time_irq, a_soft_irq, a_mtime_o}); else pass_cnt++;
    #10 rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (a_time_irq) irq_seen = 1'b1;
      if (c == 2) begin
        total_cnt++; if (a_mtime_o !== 64'd1) $display("FAIL tick_c2: got %h expected %h", a_mtime_o, 64'd1); else pass_cnt++;
      end
      if (c == 4) begin
        total_cnt++; if (a_mtime_o !== 64'd2) $display("FAIL tick_c4: got %h expected %h", a_mtime_o, 64'd2); else pass_cnt++;
      end
    end
    total_cnt++; if (a_mtime_o !== 64'd5) $display("FAIL tick_c10: got %h expected %h", a_mtime_o, 64'd5); else pass_cnt++;
    total_cnt++; if (b_mtime_o !== 64'd10) $display("FAIL tick1_c10: got %h expected %h", b_mtime_o, 64'd10); else pass_cnt++;
    total_cnt++; if (irq_seen !== 1'b0) $display("FAIL tirq_quiet: got %b expected 0", irq_seen); else pass_cnt++;
  endtask

  task automatic test_timer_irq();
    logic [63:0] rd; logic er, v1, v2;
    int guard;
    bus(1'b1, A_MCMP, 64'd10, 8'hFF, rd, er, v1, v2);
    total_cnt++; if ({v1, v2, er} !== 3'b100) $display("FAIL cmp_wr_resp: got %b expected 100", {v1, v2, er}); else pass_cnt++;
    guard = 0;
    while (a_mtime_o != 64'd10 && guard < 40) begin
      @(posedge clk); #1; guard++;
    end
    total_cnt++; if (a_mtime_o !== 64'd10) $display("FAIL reach10: got %h expected %h", a_mtime_o, 64'd10); else pass_cnt++;
    total_cnt++; if (a_time_irq !== 1'b0) $display("FAIL tirq_lag: got %b expected 0", a_time_irq); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (a_time_irq !== 1'b1) $display("FAIL tirq_rise: got %b expected 1", a_time_irq); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (a_time_irq !== 1'b1) $display("FAIL tirq_hold: got %b expected 1", a_time_irq); else pass_cnt++;
    bus(1'b1, A_MCMP, ONES, 8'hFF, rd, er, v1, v2);
    total_cnt++; if (a_time_irq !== 1'b0) $display("FAIL tirq_clear: got %b expected 0", a_time_irq); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [63:0] exp_m [4];
    logic        exp_i [4];
    exp_m[0] = 64'hFFFF_FFFF_FFFF_FFFE; exp_i[0] = 1'b0;
    exp_m[1] = 64'hFFFF_FFFF_FFFF_FFFF; exp_i[1] = 1'b0;
    exp_m[2] = 64'd0;                   exp_i[2] = 1'b1;
    exp_m[3] = 64'd1;                   exp_i[3] = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = A_MTIME; req_wdata = 64'hFFFF_FFFF_FFFF_FFFE; req_wstrb = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      total_cnt++; if ({b_mtime_o, b_time_irq} !== {exp_m[k], exp_i[k]})
        $display("FAIL wrap_%0d: got mtime=%h irq=%b expected mtime=%h irq=%b", k, b_mtime_o, b_time_irq, exp_m[k], exp_i[k]);
      else pass_cnt++;
    end
    req_valid = 1'b1; req_we = 1'b0; req_addr = A_MTIME;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total_cnt++; if ({b_resp_valid, b_resp_rdata} !== {1'b1, 64'd1}) $display("FAIL mtime_rd_preedge: got v=%b %h expected v=1 %h", b_resp_valid, b_resp_rdata, 64'd1); else pass_cnt++;
    @(posedge clk); #1;
    $display("bus we=0 addr=%h -> rdata=%h err=%0d", A_MTIME, b_resp_rdata, b_resp_err);
  endtask

  task automatic test_msip();
    logic [63:0] rd; logic er, v1, v2;
    bus(1'b1, A_MSIP, 64'h3, 8'hFF, rd, er, v1, v2);
    total_cnt++; if ({a_soft_irq, er} !== 2'b10) $display("FAIL msip_set: got irq/err %b expected 10", {a_soft_irq, er}); else pass_cnt++;
    bus(1'b0, A_MSIP, 64'h0, 8'h00, rd, er, v1, v2);
    total_cnt++; if (rd !== 64'h1) $display("FAIL msip_rd: got %h expected %h", rd, 64'h1); else pass_cnt++;
    bus(1'b1, A_MSIP, 64'h0, 8'h00, rd, er, v1, v2);
    total_cnt++; if (a_soft_irq !== 1'b1) $display("FAIL msip_nostrb: got %b expected 1", a_soft_irq); else pass_cnt++;
    bus(1'b1, A_MSIP, 64'h0, 8'h01, rd, er, v1, v2);
    total_cnt++; if (a_soft_irq !== 1'b0) $display("FAIL msip_clr: got %b expected 0", a_soft_irq); else pass_cnt++;
  endtask

  task automatic test_merge_and_errors();
    logic [63:0] rd; logic er, v1, v2;
    bus(1'b1, A_MCMP, 64'h1122_3344_5566_7788, 8'hFF, rd, er, v1, v2);
    bus(1'b1, A_MCMP, 64'hAAAA_AAAA_AAAA_BBCC, 8'h03, rd, er, v1, v2);
    bus(1'b0, A_MCMP, 64'h0, 8'h00, rd, er, v1, v2);
    total_cnt++; if (rd !== 64'h1122_3344_5566_BBCC) $display("FAIL strb_merge: got %h expected %h", rd, 64'h1122_3344_5566_BBCC); else pass_cnt++;
    bus(1'b0, 64'h0000_0000_0200_1000, 64'h0, 8'h00, rd, er, v1, v2);
    total_cnt++; if ({er, rd} !== {1'b1, 64'd0}) $display("FAIL err_unmapped: got err=%b %h expected err=1 0", er, rd); else pass_cnt++;
    bus(1'b1, 64'h0000_0000_0200_4004, 64'h0, 8'hFF, rd, er, v1, v2);
    total_cnt++; if ({er, rd} !== {1'b1, 64'd0}) $display("FAIL err_misalign: got err=%b %h expected err=1 0", er, rd); else pass_cnt++;
    bus(1'b0, A_MCMP, 64'h0, 8'h00, rd, er, v1, v2);
    total_cnt++; if ({er, rd} !== {1'b0, 64'h1122_3344_5566_BBCC}) $display("FAIL err_nowrite: got err=%b %h expected err=0 %h", er, rd, 64'h1122_3344_5566_BBCC); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd; logic er, v1, v2;
    logic ok;
    ok = 1'b1;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = A_MCMP; req_wstrb = 8'h00;
    @(posedge clk); #1;
    total_cnt++; if ({a_resp_valid, a_resp_rdata} !== {1'b1, 64'h1122_3344_5566_BBCC}) $display("FAIL hold_first: got v=%b %h expected v=1 %h", a_resp_valid, a_resp_rdata, 64'h1122_3344_5566_BBCC); else pass_cnt++;
    req_we = 1'b1; req_wdata = 64'd0; req_wstrb = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if ({a_resp_valid, a_req_ready, a_resp_rdata} !== {2'b10, 64'h1122_3344_5566_BBCC}) ok = 1'b0;
    end
    total_cnt++; if (ok !== 1'b1) $display("FAIL hold_stable: got v=%b rdy=%b %h expected v=1 rdy=0 %h", a_resp_valid, a_req_ready, a_resp_rdata, 64'h1122_3344_5566_BBCC); else pass_cnt++;
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if ({a_resp_valid, a_req_ready} !== 2'b01) $display("FAIL hold_release: got v/rdy %b expected 01", {a_resp_valid, a_req_ready}); else pass_cnt++;
    bus(1'b0, A_MCMP, 64'h0, 8'h00, rd, er, v1, v2);
    total_cnt++; if (rd !== 64'h1122_3344_5566_BBCC) $display("FAIL hold_blocked_wr: got %h expected %h", rd, 64'h1122_3344_5566_BBCC); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    logic [63:0] rd; logic er, v1, v2;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = A_MTIME; req_wstrb = 8'h00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    total_cnt++; if (a_resp_valid !== 1'b1) $display("FAIL abort_pending: got %b expected 1", a_resp_valid); else pass_cnt++;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({a_resp_valid, a_req_ready, a_resp_rdata} !== {2'b01, 64'd0}) $display("FAIL abort_resp: got v=%b rdy=%b %h expected v=0 rdy=1 0", a_resp_valid, a_req_ready, a_resp_rdata); else pass_cnt++;
    total_cnt++; if ({a_mtime_o, b_mtime_o} !== 128'd0) $display("FAIL abort_mtime: got %h %h expected 0 0", a_mtime_o, b_mtime_o); else pass_cnt++;
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    bus(1'b0, A_MCMP, 64'h0, 8'h00, rd, er, v1, v2);
    total_cnt++; if ({v1, v2, er, rd} !== {3'b100, ONES}) $display("FAIL abort_cmp_reset: got v=%b%b err=%b %h expected 100 %h", v1, v2, er, rd, ONES); else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 64'd0;
    req_wdata = 64'd0; req_wstrb = 8'd0; resp_ready = 1'b1;
    test_reset();
    test_timer_irq();
    test_wrap();
    test_msip();
    test_merge_and_errors();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
